serial_rx_deframer: RTL and testbench

//  Serial-in/parallel-out receiver, the far end of the parallel-load right-shift transmitter.

---
 rtl/rx_defs_pkg.sv | 16 +
 rtl/sipo_shift_core.sv | 32 +++
 rtl/serial_rx_deframer.sv | 129 ++++++++++++
 tb/tb_serial_rx_deframer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_defs_pkg.sv
// rtl/rx_defs_pkg.sv - shared definitions for the serial receive deframer
//
// Purpose: FSM state encodings and default parameter values shared by the
//          deframer top and its sub-modules.
// Contents: state_t (ST_IDLE, ST_SHIFT), DEFAULT_WIDTH, DEFAULT_CNT_W.
package rx_defs_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 3;

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - serial-in/parallel-out right-shift register
//
// Purpose: LSB-first assembly register. Each enabled clock inserts sin at the
//          MSB and moves everything one place toward the LSB, so after WIDTH
//          shifts the first bit received sits in q[0].
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset, clears q
//   shift_en in   1      shift on this clock
//   sin      in   1      serial data bit
//   q        out  WIDTH  register contents
module sipo_shift_core
  import rx_defs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_rx_deframer.sv
// rtl/serial_rx_deframer.sv - LSB-first serial receiver with valid/ready holding register
//
// Purpose: Frames a strobed serial bit stream into WIDTH-bit words using a
//          start-of-frame marker, presents each word through a holding
//          register with a valid/ready handshake, and reports aborted frames
//          and dropped words.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   sin        in   1      serial data bit, LSB first
//   bit_en     in   1      bit strobe; sin/sof sampled only when high
//   sof        in   1      start of frame, marks bit 0
//   dout       out  WIDTH  received word
//   dout_valid out  1      holding register full
//   dout_ready in   1      consumer accept
//   busy       out  1      frame in progress
//   frame_err  out  1      one-cycle pulse on frame abort by a new sof
//   overrun    out  1      sticky: completed word dropped
//   clr_err    in   1      synchronous clear of overrun
module serial_rx_deframer
  import rx_defs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word;
  logic             shift_en;
  logic             complete;
  logic             load;

  // In IDLE only a sof-qualified strobe starts a frame; in SHIFT every strobe
  // is sampled (a sof restarts, but the bit still enters as the new bit 0).
  assign shift_en = bit_en & ((state == ST_SHIFT) | sof);

  // The word is taken from the shifter's next value so it is available on
  // the same clock that samples the last bit.
  assign word     = {sin, sreg[WIDTH-1:1]};
  assign complete = (state == ST_SHIFT) & bit_en & ~sof & (count == LAST_CNT);
  assign load     = complete & (~dout_valid | dout_ready);

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .shift_en(shift_en),
    .sin     (sin),
    .q       (sreg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bit_en && sof) begin
            state <= ST_SHIFT;
            count <= ONE_CNT;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_en) begin
            if (sof) begin
              frame_err <= 1'b1;
              count     <= ONE_CNT;
            end else if (count == LAST_CNT) begin
              state <= ST_IDLE;
              count <= '0;
              busy  <= 1'b0;
            end else begin
              count <= count + ONE_CNT;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase

      // Reload beats accept: a completion on the accept clock keeps valid high.
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      // A new drop outranks a simultaneous clear.
      if (complete && !load) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_deframer.sv
// tb/tb_serial_rx_deframer.sv - directed self-checking bench for serial_rx_deframer
module tb_serial_rx_deframer;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       bit_en;
  logic       sof;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;

  int checks;
  int failures;

  serial_rx_deframer #(
    .WIDTH(4),
    .CNT_W(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .bit_en    (bit_en),
    .sof       (sof),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobed bit; returns #1 after the sampling edge.
  task automatic send_bit(input logic b, input logic s);
    sin    = b;
    sof    = s;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    sof    = 1'b0;
    sin    = 1'b0;
  endtask

  task automatic idle_cycle();
    bit_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    sin        = 1'b0;
    bit_en     = 1'b0;
    sof        = 1'b0;
    dout_ready = 1'b0;
    clr_err    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {4'h0, dout}, 8'h00);
    check("rst_valid", {7'h0, dout_valid}, 8'h00);
    check("rst_busy", {7'h0, busy}, 8'h00);
    check("rst_flags", {6'h0, frame_err, overrun}, 8'h00);
    rst = 1'b0;
    idle_cycle();

    // T1: 1,1,0,1 LSB first -> 4'b1011
    send_bit(1'b0, 1'b0);
    check("t1_no_sof_ignored", {7'h0, busy}, 8'h00);
    sof = 1'b1;
    idle_cycle();
    sof = 1'b0;
    check("t1_sof_no_en_ignored", {7'h0, busy}, 8'h00);
    send_bit(1'b1, 1'b1);
    check("t1_busy", {7'h0, busy}, 8'h01);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t1_valid_before_last", {7'h0, dout_valid}, 8'h00);
    send_bit(1'b1, 1'b0);
    check("t1_valid", {7'h0, dout_valid}, 8'h01);
    check("t1_dout", {4'h0, dout}, 8'h0b);
    check("t1_busy_done", {7'h0, busy}, 8'h00);
    check("t1_overrun", {7'h0, overrun}, 8'h00);

    // T2: pending word, second frame dropped
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t2_overrun", {7'h0, overrun}, 8'h01);
    check("t2_dout_stable", {4'h0, dout}, 8'h0b);
    check("t2_valid", {7'h0, dout_valid}, 8'h01);
    clr_err = 1'b1;
    idle_cycle();
    clr_err = 1'b0;
    check("t2_clr", {7'h0, overrun}, 8'h00);
    // clear coincident with a new drop: set wins
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    clr_err = 1'b1;
    send_bit(1'b1, 1'b0);
    clr_err = 1'b0;
    check("t2_set_wins", {7'h0, overrun}, 8'h01);
    check("t2_dout_stable2", {4'h0, dout}, 8'h0b);
    clr_err = 1'b1;
    idle_cycle();
    clr_err = 1'b0;
    check("t2_clr2", {7'h0, overrun}, 8'h00);

    // T3: accept on the clock of the last bit -> reload 4'b0100
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    dout_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    dout_ready = 1'b0;
    check("t3_valid", {7'h0, dout_valid}, 8'h01);
    check("t3_dout", {4'h0, dout}, 8'h04);
    check("t3_overrun", {7'h0, overrun}, 8'h00);
    dout_ready = 1'b1;
    idle_cycle();
    dout_ready = 1'b0;
    check("t3_accept", {7'h0, dout_valid}, 8'h00);

    // T4: abort after 2 bits, restart with 0,1,1,1 -> 4'b1110
    dout_ready = 1'b1;
    idle_cycle();
    dout_ready = 1'b0;
    check("t4_ready_ignored", {7'h0, dout_valid}, 8'h00);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check("t4_no_err", {7'h0, frame_err}, 8'h00);
    send_bit(1'b0, 1'b1);
    check("t4_frame_err", {7'h0, frame_err}, 8'h01);
    check("t4_busy", {7'h0, busy}, 8'h01);
    send_bit(1'b1, 1'b0);
    check("t4_err_pulse_end", {7'h0, frame_err}, 8'h00);
    send_bit(1'b1, 1'b0);
    check("t4_not_done", {7'h0, dout_valid}, 8'h00);
    send_bit(1'b1, 1'b0);
    check("t4_valid", {7'h0, dout_valid}, 8'h01);
    check("t4_dout", {4'h0, dout}, 8'h0e);
    dout_ready = 1'b1;
    idle_cycle();
    dout_ready = 1'b0;

    // T5: 1,0,1,1 with 3-clock gaps -> 4'b1101, left pending
    send_bit(1'b1, 1'b1);
    repeat (3) idle_cycle();
    check("t5_busy_gap1", {7'h0, busy}, 8'h01);
    send_bit(1'b0, 1'b0);
    repeat (3) idle_cycle();
    check("t5_busy_gap2", {7'h0, busy}, 8'h01);
    send_bit(1'b1, 1'b0);
    repeat (3) idle_cycle();
    check("t5_busy_gap3", {7'h0, busy}, 8'h01);
    check("t5_not_done", {7'h0, dout_valid}, 8'h00);
    send_bit(1'b1, 1'b0);
    check("t5_valid", {7'h0, dout_valid}, 8'h01);
    check("t5_dout", {4'h0, dout}, 8'h0d);
    check("t5_busy_done", {7'h0, busy}, 8'h00);

    // T6: async reset after 2 bits, then a clean frame 0,1,0,1 -> 4'b1010
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_dout", {4'h0, dout}, 8'h00);
    check("t6_async_valid", {7'h0, dout_valid}, 8'h00);
    check("t6_async_busy", {7'h0, busy}, 8'h00);
    check("t6_async_err", {7'h0, frame_err}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t6_not_done", {7'h0, dout_valid}, 8'h00);
    send_bit(1'b1, 1'b0);
    check("t6_valid", {7'h0, dout_valid}, 8'h01);
    check("t6_dout", {4'h0, dout}, 8'h0a);
    check("t6_flags", {6'h0, frame_err, overrun}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
